// File: rtl/rom_seg_scanner.sv
// Captures distinct ROM segment words into a 4-deep history buffer and
// scans them onto a 4-digit multiplexed seven-segment display.
module rom_seg_scanner #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] data_in,
    input  logic [3:0] addr_in,
    input  logic       ena,
    input  logic       clear,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [3:0] last_addr,
    output logic [2:0] fill
);

    localparam logic [7:0] PC_MAX = 8'(PRESCALE - 1);

    logic [3:0][6:0] buf_q, buf_d;
    logic [2:0]      fill_q, fill_d;
    logic [3:0]      last_q, last_d;
    logic [7:0]      pc_q, pc_d;
    logic [1:0]      idx_q, idx_d;
    logic            cap;
    logic            wrap;

    // A repeated tag is only a duplicate if there is something to compare against.
    assign cap  = ena & ~clear & ~((fill_q != 3'd0) & (addr_in == last_q));
    assign wrap = (pc_q == PC_MAX);

    always_comb begin
        buf_d  = buf_q;
        fill_d = fill_q;
        last_d = last_q;
        if (clear) begin
            buf_d  = '0;
            fill_d = 3'd0;
            last_d = 4'd0;
        end else if (cap) begin
            buf_d  = {buf_q[2:0], data_in};
            fill_d = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
            last_d = addr_in;
        end
    end

    always_comb begin
        pc_d  = wrap ? 8'd0 : pc_q + 8'd1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            fill_q <= 3'd0;
            last_q <= 4'd0;
            pc_q   <= 8'd0;
            idx_q  <= 2'd0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            last_q <= last_d;
            pc_q   <= pc_d;
            idx_q  <= idx_d;
        end
    end

    assign an        = ~(4'b0001 << idx_q);
    assign seg       = ({1'b0, idx_q} < fill_q) ? buf_q[idx_q] : 7'd0;
    assign last_addr = last_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_rom_seg_scanner.sv
// Directed vector bench for rom_seg_scanner with PRESCALE=4.
module tb_rom_seg_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] data_in = 7'd0;
    logic [3:0] addr_in = 4'd0;
    logic       ena = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] last_addr;
    logic [2:0] fill;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    rom_seg_scanner #(.PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .addr_in(addr_in),
        .ena(ena), .clear(clear), .seg(seg), .an(an),
        .last_addr(last_addr), .fill(fill)
    );

    typedef struct {
        logic            rst;
        logic            ena;
        logic            clr;
        logic [3:0]      addr;
        logic [6:0]      data;
        int              n;
        logic [2:0]      fill;
        logic [3:0]      last;
        logic [3:0][6:0] bufv;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(logic r, logic e, logic c, logic [3:0] a, logic [6:0] d,
                               int n, logic [2:0] f, logic [3:0] l,
                               logic [6:0] b3, logic [6:0] b2, logic [6:0] b1, logic [6:0] b0);
        vec_t t;
        t.rst = r; t.ena = e; t.clr = c; t.addr = a; t.data = d; t.n = n;
        t.fill = f; t.last = l; t.bufv = {b3, b2, b1, b0};
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then check against the row's expected state.
    task automatic step(vec_t t);
        int         ei;
        logic [3:0] ean;
        logic [6:0] eseg;
        rst = t.rst; ena = t.ena; clear = t.clr; addr_in = t.addr; data_in = t.data;
        @(posedge clk);
        #1;
        if (t.rst) cyc = 0; else cyc++;
        ei      = (cyc / 4) % 4;
        ean     = 4'b1111;
        ean[ei] = 1'b0;
        eseg    = (ei < int'(t.fill)) ? t.bufv[ei] : 7'd0;
        chk("an", 32'(an), 32'(ean));
        chk("seg", 32'(seg), 32'(eseg));
        chk("fill", 32'(fill), 32'(t.fill));
        chk("last_addr", 32'(last_addr), 32'(t.last));
    endtask

    initial begin
        int guard;
        // reset, then idle scan through all four digits
        tv.push_back(v(1, 0, 0, 4'h0, 7'h00, 2,  0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00));
        tv.push_back(v(0, 0, 0, 4'h0, 7'h00, 17, 0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00));
        // first captures, tag 0 accepted on an empty buffer
        tv.push_back(v(0, 1, 0, 4'h0, 7'h3F, 1,  1, 4'h0, 7'h00, 7'h00, 7'h00, 7'h3F));
        tv.push_back(v(0, 1, 0, 4'h1, 7'h06, 1,  2, 4'h1, 7'h00, 7'h00, 7'h3F, 7'h06));
        tv.push_back(v(0, 1, 0, 4'h2, 7'h5B, 1,  3, 4'h2, 7'h00, 7'h3F, 7'h06, 7'h5B));
        tv.push_back(v(0, 0, 0, 4'h2, 7'h00, 16, 3, 4'h2, 7'h00, 7'h3F, 7'h06, 7'h5B));
        // saturation and overflow
        tv.push_back(v(0, 1, 0, 4'h3, 7'h4F, 1,  4, 4'h3, 7'h3F, 7'h06, 7'h5B, 7'h4F));
        tv.push_back(v(0, 1, 0, 4'h4, 7'h66, 1,  4, 4'h4, 7'h06, 7'h5B, 7'h4F, 7'h66));
        // duplicate tag held, then one new tag
        tv.push_back(v(0, 1, 0, 4'h4, 7'h7F, 5,  4, 4'h4, 7'h06, 7'h5B, 7'h4F, 7'h66));
        tv.push_back(v(0, 1, 0, 4'h5, 7'h6D, 1,  4, 4'h5, 7'h5B, 7'h4F, 7'h66, 7'h6D));
        tv.push_back(v(0, 0, 0, 4'h5, 7'h00, 16, 4, 4'h5, 7'h5B, 7'h4F, 7'h66, 7'h6D));
        // ena low sweep with unknown data, then clear beats ena
        for (int a = 0; a < 5; a++)
            tv.push_back(v(0, 0, 0, 4'(a), 7'bx, 1, 4, 4'h5, 7'h5B, 7'h4F, 7'h66, 7'h6D));
        tv.push_back(v(0, 1, 1, 4'h9, 7'h11, 1,  0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00));
        tv.push_back(v(0, 0, 0, 4'h9, 7'h11, 16, 0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00));
        // refill three entries for the mid-operation reset
        tv.push_back(v(0, 1, 0, 4'h7, 7'h01, 1,  1, 4'h7, 7'h00, 7'h00, 7'h00, 7'h01));
        tv.push_back(v(0, 1, 0, 4'h8, 7'h02, 1,  2, 4'h8, 7'h00, 7'h00, 7'h01, 7'h02));
        tv.push_back(v(0, 1, 0, 4'h9, 7'h03, 1,  3, 4'h9, 7'h00, 7'h01, 7'h02, 7'h03));

        #1;
        foreach (tv[i])
            for (int k = 0; k < tv[i].n; k++)
                step(tv[i]);

        // idle until pc=2, idx=2
        guard = 0;
        while ((cyc % 16) != 10 && guard < 64) begin
            step(v(0, 0, 0, 4'h9, 7'h00, 1, 3, 4'h9, 7'h00, 7'h01, 7'h02, 7'h03));
            guard++;
        end
        n_chk++;
        if (guard >= 64) begin
            n_fail++;
            $display("FAIL align_timeout got %0d want <64", guard);
        end
        chk("an_pre_rst", 32'(an), 32'(4'b1011));
        chk("seg_pre_rst", 32'(seg), 32'(7'h01));

        // reset wins over a capturing ena
        step(v(1, 1, 0, 4'hA, 7'h77, 1, 0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00));
        step(v(0, 0, 0, 4'hA, 7'h77, 6, 0, 4'h0, 7'h00, 7'h00, 7'h00, 7'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_seg_scanner.md
Name: rom_seg_scanner

Overview:
- Downstream consumer of the 16x7 ROM stage.
- Captures the ROM's 7-bit segment word (data_out) and its echoed address (addr_out) whenever the ROM enable is high.
- Holds the four most recent distinct words in a shift buffer.
- Time-multiplexes them onto a 4-digit seven-segment display through a prescaled scan counter.

Parameters:
PRESCALE, 4, clock cycles each digit stays selected before the scan advances (legal range 1..255).

Ports:
clk        input   1  system clock; all state updates on the rising edge
rst        input   1  reset; synchronous, active-high
data_in    input   7  segment word from ROM data_out
addr_in    input   4  address tag from ROM addr_out
ena        input   1  capture qualifier (the same enable driven to the ROM)
clear      input   1  synchronous flush of buffer and tag
seg        output  7  segment pattern for the currently selected digit; 0 = blank
an         output  4  digit select, one-hot active-low; bit k low = digit k lit
last_addr  output  4  address tag of the most recently captured word
fill       output  3  number of valid buffer entries, 0..4

Behaviour:
- Reset (rst=1 at an edge) forces the following; rst has priority over clear and ena:
  - buf[0..3]=0, fill=0, last_addr=0
  - prescale counter pc=0, digit index idx=0
  - outputs: an=4'b1110, seg=7'b0000000
- Capture condition at an edge: cap = ena & ~clear & ~(fill!=0 & addr_in==last_addr).
  - Duplicate suppression: a tag equal to last_addr is ignored only while fill!=0.
  - When fill==0, any tag is captured, including 0.
- On cap:
  - buf[3]<=buf[2], buf[2]<=buf[1], buf[1]<=buf[0], buf[0]<=data_in
  - last_addr<=addr_in
  - fill<=fill+1, saturating at 4; when fill==4 the oldest entry is discarded
  - Latency: the captured word is visible on seg/fill/last_addr from the cycle after the capturing edge.
- clear=1 (rst=0) at an edge: buf=0, fill=0, last_addr=0; clear has priority over ena.
  - The scan state (pc, idx) is not touched by clear.
- Scan:
  - pc counts 0..PRESCALE-1 every cycle and wraps.
  - When pc==PRESCALE-1, idx<=idx+1 mod 4 (3->0 wrap).
  - With PRESCALE=1, idx advances every cycle.
  - Scan runs continuously, independent of ena, clear and capture.
- Output decode:
  - an = ~(4'b0001 << idx), combinational from registered idx.
  - seg = buf[idx] when idx < fill, else 7'b0 (blank). Combinational from registered state; no extra latency.
- Simultaneous capture and scan advance in one cycle: both take effect. seg at the next cycle reflects the new idx and the new buffer contents.
- ena is treated as a level. One capture per edge at most, so a word held for N cycles under a constant tag is captured once.
- Widths:
  - fill is 3 bits with saturation, never wraps.
  - idx is 2 bits with natural wrap.
  - pc is 8 bits and is compared to PRESCALE-1.
- X on data_in while ena=0 must not propagate into buf.

Test Plan:
1. Reset, PRESCALE=4: assert rst 2 cycles, then release -> an=1110, seg=0, fill=0, last_addr=0. an then steps 1101, 1011, 0111, 1110 with each value held exactly 4 cycles.
2. Capture sequence: ena=1, drive (addr,data)=(0,7'h3F),(1,7'h06),(2,7'h5B), one per cycle ->
   - fill ends at 3, last_addr=2
   - seg shows 5B on digit 0, 06 on digit 1, 3F on digit 2
   - digit 3 is blank (seg=0)
3. Saturation/overflow: continue with (3,7'h4F),(4,7'h66) -> fill stays 4. buf[0..3] = 66, 4F, 5B, 06 (3F discarded).
4. Duplicate suppression: hold addr=4, data=7'h7F with ena=1 for 5 cycles -> buf unchanged, fill=4. Then addr=5, data=7'h6D -> one capture, buf[0]=6D.
5. ena low and clear: ena=0 with addr sweeping 0..4 -> no buffer change. Then clear=1 for 1 cycle with ena=1 -> fill=0, seg=0 on all digits, scan phase continues uninterrupted.
6. Mid-operation reset: assert rst while pc=2, idx=2, fill=3, with ena=1 -> next cycle all state is 0, an=1110, and the cycle's ena capture is not performed.
